spi_slave_responder: RTL and testbench

Mode-3 SPI slave (CPOL=1, CPHA=1), MSB first, 8-bit frames; the responder end of the team's SPI master link. It oversamples `cs_bar`, `sclk` and `din_mosi` in the `clk` domain, delivers each received byte on `rx_data`/`rx_valid`, and shifts out a byte preloaded through a `tx_valid`/`tx_ready` handshake on `dout_miso`. It sits between the SPI pads and the register/multiplier logic.

---
 rtl/spi_slave_responder.sv | 207 ++++++++++++++++++++
 tb/tb_spi_slave_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_responder.sv
// spi_slave_responder
//   Mode-3 SPI slave (CPOL=1, CPHA=1), MSB first, DATA_WIDTH-bit frames.
//   cs_bar, sclk and din_mosi are oversampled in the clk domain. Each received
//   frame is presented on rx_data with a one-cycle rx_valid pulse. The byte to
//   transmit is preloaded into a holding register via tx_valid/tx_ready.
//
//   Optional feature macro: SPI_SLAVE_UNDERRUN_EN
//     defined   -> tx_underrun pulses when a frame starts with an empty holding register
//     undefined -> tx_underrun tied 0 (underrun frames still transmit all zeros)
//
// Ports
//   clk, reset   system clock, asynchronous active-high reset
//   cs_bar       chip select (active low, asynchronous)
//   sclk         SPI clock (idles high, asynchronous)
//   din_mosi     master-out data
//   dout_miso    slave-out data (0 whenever not selected)
//   miso_oe      pad output enable (= synchronized select)
//   tx_data      byte for the next frame, captured on tx_valid && tx_ready
//   tx_valid     tx_data valid
//   tx_ready     holding register empty
//   rx_data      last complete received frame
//   rx_valid     one-cycle pulse, rx_data updated
//   frame_abort  one-cycle pulse, select dropped mid-frame
//   tx_underrun  one-cycle pulse, frame started with empty holding register
//   busy         select active
module spi_slave_responder #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs_bar,
    input  logic                  sclk,
    input  logic                  din_mosi,
    output logic                  dout_miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_abort,
    output logic                  tx_underrun,
    output logic                  busy
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMPLETE} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
    logic                   sclk_dly;
    logic                   armed;
    logic                   cs_s, sclk_s, mosi_s;
    logic                   rise, fall, sel;

    logic [CW-1:0]          bit_cnt;
    logic [DATA_WIDTH-1:0]  tx_shift;
    // Only the first DATA_WIDTH-1 bits are held; the last bit goes straight
    // into rx_data together with these.
    logic [DATA_WIDTH-2:0]  rx_shift;
    logic [DATA_WIDTH-1:0]  hold_data;
    logic                   hold_full;

    logic load, shift_tx, shift_rx, last_bit, abort, clr;

    // Synchronizers and sclk edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync   <= '0;
            sclk_sync <= '1;
            mosi_sync <= '0;
            sclk_dly  <= 1'b1;
            armed     <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_bar};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], din_mosi};
            sclk_dly  <= sclk_s;
            // After reset a select only counts once cs_bar has been seen high,
            // so a select that was in progress at reset is ignored.
            if (cs_s)
                armed <= 1'b1;
        end
    end

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_dly;
    assign fall   = ~sclk_s & sclk_dly;
    assign sel    = armed & ~cs_s;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state and datapath controls
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_tx = 1'b0;
        shift_rx = 1'b0;
        last_bit = 1'b0;
        abort    = 1'b0;
        clr      = 1'b0;
        case (state_q)
            IDLE: begin
                clr = 1'b1;
                if (sel)
                    state_d = SHIFT;
            end
            SHIFT: begin
                if (!sel) begin
                    abort   = (bit_cnt != '0);
                    state_d = IDLE;
                end else if (fall) begin
                    if (bit_cnt == '0)
                        load = 1'b1;
                    else
                        shift_tx = 1'b1;
                end else if (rise) begin
                    shift_rx = 1'b1;
                    if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                        last_bit = 1'b1;
                        state_d  = COMPLETE;
                    end
                end
            end
            COMPLETE: begin
                state_d = sel ? SHIFT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_abort <= abort;
            // Registered on the completing rise so that rx_valid and the new
            // rx_data are both visible during the single COMPLETE cycle.
            rx_valid    <= last_bit;

            // A capture can only happen while empty, so a same-cycle frame
            // start sees empty and the new byte waits for the next frame.
            if (load && hold_full) begin
                hold_full <= 1'b0;
            end else if (tx_valid && !hold_full) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end

            if (clr || state_q == COMPLETE)
                bit_cnt <= '0;
            else if (shift_rx)
                bit_cnt <= bit_cnt + CW'(1);

            if (clr) begin
                tx_shift <= '0;
                rx_shift <= '0;
            end else begin
                if (load)
                    tx_shift <= hold_full ? hold_data : '0;
                else if (shift_tx)
                    tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                if (shift_rx) begin
                    rx_shift <= {rx_shift[DATA_WIDTH-3:0], mosi_s};
                    if (last_bit)
                        rx_data <= {rx_shift, mosi_s};
                end
            end
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    logic underrun_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            underrun_q <= 1'b0;
        else
            underrun_q <= load && !hold_full;
    end
    assign tx_underrun = underrun_q;
`else
    assign tx_underrun = 1'b0;
`endif

    assign dout_miso = sel & tx_shift[DATA_WIDTH-1];
    assign miso_oe   = sel;
    assign busy      = sel;
    assign tx_ready  = ~hold_full;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Testbench for spi_slave_responder: a behavioural SPI master drives mode-3
// frames; expectations come from the frame-level rules (rx = byte sent by the
// master, miso = preloaded byte or zero).
module tb_spi_slave_responder;
    localparam int H = 8;   // sclk half-period in clk cycles
`ifdef SPI_SLAVE_UNDERRUN_EN
    localparam int UND_EN = 1;
`else
    localparam int UND_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       reset, cs_bar, sclk, din_mosi, tx_valid;
    logic [7:0] tx_data;
    logic       dout_miso, miso_oe, tx_ready, rx_valid, frame_abort, tx_underrun, busy;
    logic [7:0] rx_data;

    int checks = 0, errors = 0;
    int rv_cnt = 0, ab_cnt = 0, un_cnt = 0, width_err = 0, overlap_err = 0;
    logic [7:0] rx_q[$];
    logic prev_rv = 1'b0, prev_ab = 1'b0, prev_un = 1'b0;

    spi_slave_responder #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .cs_bar(cs_bar), .sclk(sclk), .din_mosi(din_mosi),
        .dout_miso(dout_miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_abort(frame_abort), .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) begin
                rv_cnt++;
                rx_q.push_back(rx_data);
            end
            if (frame_abort) ab_cnt++;
            if (tx_underrun) un_cnt++;
            if ((rx_valid && prev_rv) || (frame_abort && prev_ab) || (tx_underrun && prev_un))
                width_err++;
            if (rx_valid && frame_abort) overlap_err++;
        end
        prev_rv = rx_valid;
        prev_ab = frame_abort;
        prev_un = tx_underrun;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic sel_on();
        cs_bar = 1'b0;
        tick(6);
    endtask

    task automatic sel_off();
        cs_bar = 1'b1;
        tick(6);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        sclk     = 1'b0;
        din_mosi = b;
        tick(H);
        m        = dout_miso;   // master samples just before its rising edge
        sclk     = 1'b1;
        tick(H);
    endtask

    task automatic spi_frame(input logic [7:0] mo, output logic [7:0] mi);
        logic m;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(mo[i], m);
            mi[i] = m;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " dout_miso"},   32'(dout_miso),   32'h0);
        check({tag, " miso_oe"},     32'(miso_oe),     32'h0);
        check({tag, " tx_ready"},    32'(tx_ready),    32'h1);
        check({tag, " rx_data"},     32'(rx_data),     32'h0);
        check({tag, " rx_valid"},    32'(rx_valid),    32'h0);
        check({tag, " frame_abort"}, 32'(frame_abort), 32'h0);
        check({tag, " tx_underrun"}, 32'(tx_underrun), 32'h0);
        check({tag, " busy"},        32'(busy),        32'h0);
    endtask

    typedef struct {
        bit         pre;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        int         exp_und;
    } vec_t;

    initial begin
        vec_t       vt[4];
        logic [7:0] g, g2;
        logic       m;
        int         s_rv, s_un, s_ab;
        logic [7:0] exp_rx[$];

        vt[0] = '{1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 0};
        vt[1] = '{1'b0, 8'h00, 8'hFF, 8'hFF, 8'h00, UND_EN};
        vt[2] = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF, 0};
        vt[3] = '{1'b1, 8'h81, 8'h7E, 8'h7E, 8'h81, 0};

        reset = 1'b1; cs_bar = 1'b1; sclk = 1'b1; din_mosi = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00;
        tick(3);
        reset = 1'b0;
        tick(4);
        check_reset_outputs("reset");

        // Table-driven single frames
        for (int i = 0; i < 4; i++) begin
            s_rv = rv_cnt; s_un = un_cnt; s_ab = ab_cnt;
            if (vt[i].pre) begin
                preload(vt[i].tx);
                check("tbl tx_ready full", 32'(tx_ready), 32'h0);
            end
            sel_on();
            check("tbl busy", 32'(busy), 32'h1);
            check("tbl miso_oe", 32'(miso_oe), 32'h1);
            spi_frame(vt[i].mosi, g);
            sel_off();
            check("tbl miso byte", 32'(g), 32'(vt[i].exp_miso));
            check("tbl rx_data", 32'(rx_data), 32'(vt[i].exp_rx));
            check("tbl rx_valid count", 32'(rv_cnt - s_rv), 32'd1);
            check("tbl underrun count", 32'(un_cnt - s_un), 32'(vt[i].exp_und));
            check("tbl abort count", 32'(ab_cnt - s_ab), 32'd0);
        end

        // tx_ready returns at the frame's first fall; MSB driven right after
        preload(8'hA5);
        sel_on();
        check("txr before fall", 32'(tx_ready), 32'h0);
        spi_bit(1'b0, m);
        check("txr after first fall", 32'(tx_ready), 32'h1);
        check("first miso bit", 32'(m), 32'h1);
        g[7] = m;
        for (int i = 6; i >= 0; i--) begin
            spi_bit(1'b0, m);
            g[i] = m;
        end
        sel_off();
        check("A5 miso byte", 32'(g), 32'hA5);

        // Back-to-back frames under one select
        s_rv = rv_cnt; s_un = un_cnt; s_ab = ab_cnt; rx_q.delete();
        preload(8'h11);
        sel_on();
        spi_frame(8'h81, g);
        preload(8'h22);
        spi_frame(8'h7E, g2);
        sel_off();
        check("b2b rx_valid count", 32'(rv_cnt - s_rv), 32'd2);
        check("b2b rx0", 32'(rx_q.size() > 0 ? rx_q[0] : 8'hxx), 32'h81);
        check("b2b rx1", 32'(rx_q.size() > 1 ? rx_q[1] : 8'hxx), 32'h7E);
        check("b2b miso0", 32'(g), 32'h11);
        check("b2b miso1", 32'(g2), 32'h22);
        check("b2b underrun", 32'(un_cnt - s_un), 32'd0);
        check("b2b abort", 32'(ab_cnt - s_ab), 32'd0);

        // Abort after 5 bits; preloaded byte is lost
        s_rv = rv_cnt; s_ab = ab_cnt;
        preload(8'h5C);
        sel_on();
        for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
        cs_bar = 1'b1;
        tick(8);
        check("abort count", 32'(ab_cnt - s_ab), 32'd1);
        check("abort no rx_valid", 32'(rv_cnt - s_rv), 32'd0);
        check("abort rx_data held", 32'(rx_data), 32'h7E);
        check("abort dout_miso", 32'(dout_miso), 32'h0);
        check("abort miso_oe", 32'(miso_oe), 32'h0);
        check("abort busy", 32'(busy), 32'h0);
        check("abort tx_ready", 32'(tx_ready), 32'h1);
        s_un = un_cnt;
        sel_on();
        spi_frame(8'h24, g);
        sel_off();
        check("post-abort miso", 32'(g), 32'h00);
        check("post-abort rx", 32'(rx_data), 32'h24);
        check("post-abort underrun", 32'(un_cnt - s_un), 32'(UND_EN));

        // Reset mid-frame, released while still selected
        sel_on();
        for (int i = 0; i < 3; i++) spi_bit(1'b1, m);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        check_reset_outputs("midreset");
        s_rv = rv_cnt; s_ab = ab_cnt;
        spi_frame(8'hC3, g);
        check("midreset ignored rx", 32'(rv_cnt - s_rv), 32'd0);
        check("midreset ignored abort", 32'(ab_cnt - s_ab), 32'd0);
        check("midreset busy", 32'(busy), 32'h0);
        sel_off();
        preload(8'h3D);
        sel_on();
        spi_frame(8'h5A, g);
        sel_off();
        check("after reset rx", 32'(rx_data), 32'h5A);
        check("after reset miso", 32'(g), 32'h3D);

        // tx_valid held while holding register full
        preload(8'h44);
        tx_data  = 8'h99;
        tx_valid = 1'b1;
        tick(4);
        check("hold keeps full", 32'(tx_ready), 32'h0);
        sel_on();
        spi_frame(8'h55, g);
        check("hold recaptured", 32'(tx_ready), 32'h0);
        tx_valid = 1'b0;
        sel_off();
        check("hold miso 44", 32'(g), 32'h44);
        sel_on();
        spi_frame(8'hAA, g);
        sel_off();
        check("hold miso 99", 32'(g), 32'h99);
        check("hold empty", 32'(tx_ready), 32'h1);

        // Randomized selects of 1..3 frames against the frame-level model
        for (int r = 0; r < 12; r++) begin
            int nf, e_un;
            nf = int'($urandom_range(1, 3));
            e_un = 0;
            s_rv = rv_cnt; s_un = un_cnt; s_ab = ab_cnt;
            rx_q.delete(); exp_rx.delete();
            sel_on();
            for (int f = 0; f < nf; f++) begin
                bit         pre;
                logic [7:0] b, mo;
                pre = 1'($urandom);
                b   = 8'($urandom);
                mo  = 8'($urandom);
                if (pre) preload(b);
                else e_un += UND_EN;
                spi_frame(mo, g);
                check("rand miso", 32'(g), pre ? 32'(b) : 32'h0);
                exp_rx.push_back(mo);
            end
            sel_off();
            check("rand rx count", 32'(rv_cnt - s_rv), 32'(nf));
            for (int f = 0; f < nf; f++)
                check("rand rx byte", 32'(rx_q.size() > f ? rx_q[f] : 8'hxx), 32'(exp_rx[f]));
            check("rand underrun", 32'(un_cnt - s_un), 32'(e_un));
            check("rand abort", 32'(ab_cnt - s_ab), 32'd0);
        end

        check("pulse widths", 32'(width_err), 32'd0);
        check("rx_valid/abort overlap", 32'(overlap_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
